// File: rtl/contador_bits_um.sv
// Ones-counter: combinational popcount of the input word, plus a registered
// copy with status flags and a saturating running total of captured counts.
module contador_bits_um #(
    parameter int LARGURA   = 8,
    parameter int LARG_ACUM = 16,
    localparam int LARG_CONT = $clog2(LARGURA + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [LARGURA-1:0]   entrada,
    input  logic                 en,
    output logic [LARG_CONT-1:0] saida_quant_um,
    output logic [LARG_CONT-1:0] saida_reg,
    output logic                 valido,
    output logic                 zero,
    output logic                 cheio,
    output logic                 paridade,
    output logic [LARG_ACUM-1:0] total_acum
);

    // One extra bit of headroom so the carry out of the add reveals saturation.
    localparam int LARG_SOMA = ((LARG_ACUM > LARG_CONT) ? LARG_ACUM : LARG_CONT) + 1;
    localparam logic [LARG_SOMA-1:0] MAX_ACUM = LARG_SOMA'({LARG_ACUM{1'b1}});

    logic [LARGURA-1:0]   entrada_um;
    logic [LARG_CONT-1:0] contagem;
    logic [LARG_SOMA-1:0] soma;

    // entrada is routed through a local copy so the loop reads one clean vector
    assign entrada_um = entrada;

    always_comb begin
        contagem = '0;
        for (int i = 0; i < LARGURA; i++) begin
            contagem = contagem + LARG_CONT'(entrada_um[i]);
        end
    end

    assign saida_quant_um = contagem;

    always_comb begin
        soma = LARG_SOMA'(total_acum) + LARG_SOMA'(contagem);
        if (soma > MAX_ACUM) begin
            soma = MAX_ACUM;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            saida_reg  <= '0;
            valido     <= 1'b0;
            zero       <= 1'b0;
            cheio      <= 1'b0;
            paridade   <= 1'b0;
            total_acum <= '0;
        end else if (en) begin
            saida_reg  <= contagem;
            valido     <= 1'b1;
            zero       <= (entrada == '0);
            cheio      <= (&entrada);
            paridade   <= contagem[0];
            total_acum <= soma[LARG_ACUM-1:0];
        end else begin
            valido     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_contador_bits_um.sv
// Directed self-checking bench for contador_bits_um; a second instance with a
// 4-bit accumulator exercises saturation.
module tb_contador_bits_um;

    logic       clk;
    logic       reset;
    logic [7:0] entrada;
    logic       en;

    logic [3:0]  saida_quant_um, saida_reg;
    logic        valido, zero, cheio, paridade;
    logic [15:0] total_acum;

    logic [3:0] sat_quant_um, sat_reg;
    logic       sat_valido, sat_zero, sat_cheio, sat_paridade;
    logic [3:0] sat_total;

    int n_checks = 0;
    int n_errors = 0;

    contador_bits_um #(.LARGURA(8), .LARG_ACUM(16)) dut (
        .clk(clk), .reset(reset), .entrada(entrada), .en(en),
        .saida_quant_um(saida_quant_um), .saida_reg(saida_reg), .valido(valido),
        .zero(zero), .cheio(cheio), .paridade(paridade), .total_acum(total_acum)
    );

    contador_bits_um #(.LARGURA(8), .LARG_ACUM(4)) dut_sat (
        .clk(clk), .reset(reset), .entrada(entrada), .en(en),
        .saida_quant_um(sat_quant_um), .saida_reg(sat_reg), .valido(sat_valido),
        .zero(sat_zero), .cheio(sat_cheio), .paridade(sat_paridade), .total_acum(sat_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] valor, input logic habilita);
        @(negedge clk);
        entrada = valor;
        en      = habilita;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, " saida_reg"}, int'(saida_reg), 0);
        check_output({tag, " valido"}, int'(valido), 0);
        check_output({tag, " zero"}, int'(zero), 0);
        check_output({tag, " cheio"}, int'(cheio), 0);
        check_output({tag, " paridade"}, int'(paridade), 0);
        check_output({tag, " total_acum"}, int'(total_acum), 0);
        check_output({tag, " sat_total"}, int'(sat_total), 0);
    endtask

    typedef struct { logic [7:0] valor; int conta; } vetor_t;
    vetor_t diretos[6] = '{'{8'h00, 0}, '{8'h01, 1}, '{8'hA5, 4},
                           '{8'h7F, 7}, '{8'hFF, 8}, '{8'h80, 1}};

    typedef struct { logic [7:0] valor; int reg_esp; int par; int total; } acum_t;
    acum_t acumulacao[4] = '{'{8'h0F, 4, 0, 4}, '{8'h03, 2, 0, 6},
                             '{8'h01, 1, 1, 7}, '{8'hFF, 8, 0, 15}};

    initial begin
        reset   = 1'b1;
        en      = 1'b0;
        entrada = 8'h00;
        #2;
        check_reset_state("reset");

        @(negedge clk);
        reset = 1'b0;

        // Combinational popcount: hand-computed vectors, then full sweep with en=0
        foreach (diretos[k]) begin
            @(negedge clk);
            entrada = diretos[k].valor;
            #1;
            check_output($sformatf("quant_um 0x%02h", diretos[k].valor),
                         int'(saida_quant_um), diretos[k].conta);
        end
        for (int v = 0; v < 256; v++) begin
            @(negedge clk);
            entrada = 8'(v);
            #1;
            check_output($sformatf("sweep 0x%02h", v), int'(saida_quant_um), $countones(v));
        end
        check_reset_state("after sweep");

        // Registered capture of all-ones then all-zeros
        apply_stimulus(8'hFF, 1'b1);
        check_output("cap ff saida_reg", int'(saida_reg), 8);
        check_output("cap ff cheio", int'(cheio), 1);
        check_output("cap ff zero", int'(zero), 0);
        check_output("cap ff valido", int'(valido), 1);
        check_output("cap ff paridade", int'(paridade), 0);
        apply_stimulus(8'h00, 1'b1);
        check_output("cap 00 saida_reg", int'(saida_reg), 0);
        check_output("cap 00 zero", int'(zero), 1);
        check_output("cap 00 cheio", int'(cheio), 0);
        check_output("cap 00 valido", int'(valido), 1);
        check_output("cap 00 total_acum", int'(total_acum), 8);

        // Clear with a short reset pulse between edges
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;

        // Running total, then hold with en low
        foreach (acumulacao[k]) begin
            apply_stimulus(acumulacao[k].valor, 1'b1);
            check_output($sformatf("acum %0d saida_reg", k), int'(saida_reg), acumulacao[k].reg_esp);
            check_output($sformatf("acum %0d paridade", k), int'(paridade), acumulacao[k].par);
            check_output($sformatf("acum %0d total_acum", k), int'(total_acum), acumulacao[k].total);
            check_output($sformatf("acum %0d sat_total", k), int'(sat_total), acumulacao[k].total);
        end
        apply_stimulus(8'h55, 1'b0);
        check_output("hold valido", int'(valido), 0);
        check_output("hold total_acum", int'(total_acum), 15);
        check_output("hold saida_reg", int'(saida_reg), 8);
        check_output("hold cheio", int'(cheio), 1);

        // Asynchronous reset between edges
        #3;
        entrada = 8'h3C;
        reset   = 1'b1;
        #1;
        check_reset_state("async reset");
        check_output("async quant_um", int'(saida_quant_um), 4);

        @(negedge clk);
        reset = 1'b0;

        // Saturation of the 4-bit accumulator
        apply_stimulus(8'hFF, 1'b1);
        check_output("sat 1 total", int'(sat_total), 8);
        apply_stimulus(8'hFF, 1'b1);
        check_output("sat 2 total", int'(sat_total), 15);
        apply_stimulus(8'hFF, 1'b1);
        check_output("sat 3 total", int'(sat_total), 15);
        check_output("sat 3 wide total", int'(total_acum), 24);
        apply_stimulus(8'h01, 1'b1);
        check_output("sat 4 total", int'(sat_total), 15);
        check_output("sat 4 valido", int'(sat_valido), 1);
        check_output("sat 4 paridade", int'(sat_paridade), 1);

        // Reset asserted together with an enabled edge wins
        @(negedge clk);
        entrada = 8'hFF;
        en      = 1'b1;
        @(posedge clk);
        reset = 1'b1;
        #1;
        check_reset_state("reset at edge");
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/contador_bits_um.md
Name: contador_bits_um

Overview:
- Population-count (ones-counter) block: reports how many bits of an 8-bit input word are 1.
- Primary result is purely combinational, for use inside a single cycle.
- Also provides a registered copy of the count, status flags and a saturating running total of ones for downstream statistics logic.
- Sits in the datapath as a leaf utility block; one clock domain.

Parameters:
- LARGURA, 8, input word width in bits; count width is $clog2(LARGURA+1), which gives 4 for the default.
- LARG_ACUM, 16, width of the running-total accumulator.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- entrada  input  LARGURA  word whose 1-bits are counted.
- en  input  1  capture enable for the registered outputs and accumulator.
- saida_quant_um  output  4  combinational count of 1-bits in entrada (0..8).
- saida_reg  output  4  registered count, captured when en=1.
- valido  output  1  high for one cycle after each enabled capture.
- zero  output  1  registered flag: captured word was all zeros.
- cheio  output  1  registered flag: captured word was all ones.
- paridade  output  1  registered odd parity, equal to saida_reg[0].
- total_acum  output  LARG_ACUM  saturating sum of all captured counts.

Behaviour:
- saida_quant_um:
  - Pure combinational function of entrada; no clock and no reset dependence.
  - Settles within the same cycle as entrada changes; latency is 0.
  - Value equals the number of bits of entrada at 1. Range is 0 to LARGURA, so no overflow is possible in 4 bits for LARGURA=8.
  - X or Z bits on entrada may propagate X to the output; the output is always defined for 0/1 inputs.
- Reset (asynchronous, active-high):
  - While reset=1: saida_reg=0, valido=0, zero=0, cheio=0, paridade=0, total_acum=0.
  - Reset takes effect immediately, mid-cycle included, and discards any in-flight capture.
  - The first capture can occur on the first rising clk edge with reset=0.
- Rising clk edge with reset=0 and en=1:
  - saida_reg <= popcount(entrada).
  - valido <= 1.
  - zero <= (entrada == 0).
  - cheio <= (entrada all ones).
  - paridade <= popcount(entrada)[0].
  - total_acum <= total_acum + popcount(entrada), saturating at 2^LARG_ACUM-1. It never wraps; once saturated it holds until reset.
- Rising clk edge with reset=0 and en=0:
  - valido <= 0.
  - All other registered outputs hold their values.
- Latency: registered outputs reflect entrada from the enabled edge, visible 1 cycle after the capture edge.
- Simultaneous reset and clock edge: reset wins.
- There is no state machine; the only state is the registers listed above.

Test Plan:
- Exhaustive sweep: entrada 0x00..0xFF, each value held one cycle, en=0 -> saida_quant_um equals popcount before the next edge, e.g. 0x00->0, 0x01->1, 0xA5->4, 0x7F->7, 0xFF->8; registered outputs stay at reset values.
- Registered capture: en=1, entrada=0xFF, then 0x00 -> after the first edge saida_reg=8, cheio=1, zero=0, valido=1, paridade=0; after the second edge saida_reg=0, zero=1, cheio=0.
- Accumulation: en=1 for 4 cycles with 0x0F, 0x03, 0x01, 0xFF -> total_acum goes 4, 6, 7, 15; en dropped -> valido=0 and total_acum holds 15.
- Saturation with LARG_ACUM=4: capture 0xFF twice -> total_acum=15, stays 15 on further captures.
- Asynchronous reset mid-cycle: assert reset between edges with total_acum=15 -> all registered outputs go to 0 immediately while saida_quant_um still tracks entrada.
